// File: rtl/modmul_serial_if.sv
// rtl/modmul_serial_if.sv - operand/result handshake bundle for modmul_serial
interface modmul_serial_if #(
  parameter int WIDTH = 128
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, a, b, n, out_ready,
    input  in_ready, out_valid, result, out_err, busy
  );

  modport slave (
    input  in_valid, a, b, n, out_ready,
    output in_ready, out_valid, result, out_err, busy
  );
endinterface

// File: rtl/modmul_serial.sv
// rtl/modmul_serial.sv - serial MSB-first modular multiplier, result = (a*b) mod n
module modmul_serial #(
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           reset,
  modmul_serial_if.slave bus
);
  localparam int EW    = WIDTH + 2;
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q, n_q, r, result_q;
  logic [CNT_W-1:0] cnt;
  logic             out_err_q;
  logic             reject;
  logic             a_bit;
  logic [EW-1:0]    n_ext, t0, t1;
  logic [WIDTH-1:0] r_next;

  // Invariant r < n and b < n keeps t0 below 3n, so two conditional subtracts suffice.
  always_comb begin
    reject = (bus.n == '0) || (bus.a >= bus.n) || (bus.b >= bus.n);
    n_ext  = {2'b00, n_q};
    a_bit  = a_q[cnt[IDX_W-1:0]];
    t0     = {1'b0, r, 1'b0} + {2'b00, (a_bit ? b_q : {WIDTH{1'b0}})};
    t1     = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    r_next = WIDTH'((t1 >= n_ext) ? (t1 - n_ext) : t1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = reject ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      r         <= '0;
      cnt       <= '0;
      result_q  <= '0;
      out_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
            n_q <= bus.n;
            r   <= '0;
            cnt <= CNT_W'(WIDTH - 1);
            if (reject) begin
              result_q  <= '0;
              out_err_q <= 1'b1;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            result_q  <= r_next;
            out_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.out_err = out_err_q;
endmodule

// File: tb/tb_modmul_serial.sv
// tb/tb_modmul_serial.sv - randomized and directed checks of modmul_serial at WIDTH 8 and 128
module tb_modmul_serial;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modmul_serial_if #(.WIDTH(8))   bus8 ();
  modmul_serial_if #(.WIDTH(128)) bus128 ();

  modmul_serial #(.WIDTH(8))   dut8   (.clk(clk), .reset(reset), .bus(bus8));
  modmul_serial #(.WIDTH(128)) dut128 (.clk(clk), .reset(reset), .bus(bus128));

  int   checks = 0;
  int   failures = 0;
  logic sel = 1'b0;

  wire         cur_ov   = sel ? bus128.out_valid : bus8.out_valid;
  wire         cur_ir   = sel ? bus128.in_ready  : bus8.in_ready;
  wire         cur_busy = sel ? bus128.busy      : bus8.busy;
  wire         cur_err  = sel ? bus128.out_err   : bus8.out_err;
  wire [127:0] cur_res  = sel ? bus128.result    : {120'b0, bus8.result};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mulmod(input logic [127:0] a, input logic [127:0] b,
                                              input logic [127:0] n, output logic err);
    logic [255:0] p;
    if (n == 0 || a >= n || b >= n) begin
      err = 1'b1;
      return 128'd0;
    end
    err = 1'b0;
    p = ({128'b0, a} * {128'b0, b}) % {128'b0, n};
    return p[127:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [127:0] a, input logic [127:0] b, input logic [127:0] n);
    if (sel) begin
      bus128.in_valid = v; bus128.a = a; bus128.b = b; bus128.n = n;
    end else begin
      bus8.in_valid = v; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.n = n[7:0];
    end
  endtask

  task automatic drive_ordy(input logic v);
    if (sel) bus128.out_ready = v;
    else     bus8.out_ready = v;
  endtask

  task automatic run_op(input logic s, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] n, input string tag);
    logic [127:0] exp_res;
    logic         exp_err;
    int           edges;
    int           w;
    sel = s;
    w = s ? 128 : 8;
    exp_res = ref_mulmod(a, b, n, exp_err);
    check({tag, "_ready"}, cur_ir, 1);
    drive_in(1'b1, a, b, n);
    step();
    drive_in(1'b0, rand128(), rand128(), rand128());
    check({tag, "_busy"}, cur_busy, !exp_err);
    edges = 1;
    while (!cur_ov && edges < 300) begin
      step();
      edges++;
    end
    check({tag, "_lat"}, edges, exp_err ? 1 : w + 1);
    check({tag, "_res"}, cur_res, exp_res);
    check({tag, "_err"}, cur_err, exp_err);
    drive_ordy(1'b1);
    step();
    drive_ordy(1'b0);
    check({tag, "_idle"}, cur_ir, 1);
  endtask

  logic [7:0] d8 [10][3] = '{
    '{8'd5,   8'd7,   8'd11}, '{8'd0,   8'd10,  8'd11}, '{8'd0,  8'd0,  8'd1},
    '{8'd10,  8'd10,  8'd11}, '{8'd3,   8'd12,  8'd11}, '{8'd3,  8'd3,  8'd0},
    '{8'd254, 8'd254, 8'd255}, '{8'd11, 8'd2,   8'd11}, '{8'd1,  8'd1,  8'd2},
    '{8'd200, 8'd199, 8'd251}
  };

  initial begin
    logic [127:0] ra, rb, rn, er, big;
    logic         ee;
    int           bad, cnt;

    reset = 1'b1;
    sel = 1'b0;
    drive_in(1'b0, 0, 0, 0);  drive_ordy(1'b0);
    sel = 1'b1;
    drive_in(1'b0, 0, 0, 0);  drive_ordy(1'b0);
    sel = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_ready", bus8.in_ready, 1);
    check("rst_valid", bus8.out_valid, 0);
    check("rst_busy",  bus8.busy, 0);
    check("rst_res",   bus8.result, 0);
    check("rst_err",   bus8.out_err, 0);
    check("rst_res128", bus128.result, 0);

    foreach (d8[i]) run_op(1'b0, d8[i][0], d8[i][1], d8[i][2], $sformatf("dir8_%0d", i));

    big = (128'd1 << 127) - 1;
    run_op(1'b1, big - 1, big - 1, big, "dir128_a");
    big = ~128'd0;
    run_op(1'b1, big - 1, big - 1, big, "dir128_b");

    for (int i = 0; i < 40; i++) begin
      rn = 128'($urandom_range(0, 255));
      if (rn != 0 && $urandom_range(0, 7) != 0) begin
        ra = 128'($urandom) % rn;
        rb = 128'($urandom) % rn;
      end else begin
        ra = 128'($urandom_range(0, 255));
        rb = 128'($urandom_range(0, 255));
      end
      run_op(1'b0, ra, rb, rn, $sformatf("rnd8_%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      rn = rand128();
      if (i == 0) rn[127] = 1'b1;
      if (rn == 0) rn = 1;
      ra = rand128() % rn;
      rb = rand128() % rn;
      run_op(1'b1, ra, rb, rn, $sformatf("rnd128_%0d", i));
    end

    // Backpressure: result must hold and new operands must be ignored while DONE stalls.
    sel = 1'b0;
    er = ref_mulmod(100, 200, 211, ee);
    drive_in(1'b1, 100, 200, 211);
    step();
    drive_in(1'b0, 0, 0, 0);
    cnt = 0;
    while (!cur_ov && cnt < 100) begin step(); cnt++; end
    check("bp_reach", cur_ov, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive_in(1'b1, 1, 2, 3);
      step();
      if (cur_res !== er || cur_ir !== 1'b0 || cur_ov !== 1'b1) bad++;
    end
    drive_in(1'b0, 0, 0, 0);
    check("bp_stable", bad, 0);
    check("bp_res", cur_res, er);
    drive_ordy(1'b1);
    step();
    drive_ordy(1'b0);
    check("bp_idle", cur_ir, 1);
    check("bp_ov_low", cur_ov, 0);
    repeat (3) step();
    check("bp_no_accept", {cur_busy, cur_ov}, 0);

    // Throughput with in_valid and out_ready both held high.
    er = ref_mulmod(9, 13, 17, ee);
    drive_in(1'b1, 9, 13, 17);
    drive_ordy(1'b1);
    cnt = 0;
    while (!cur_ov && cnt < 100) begin step(); cnt++; end
    check("tp_res1", cur_res, er);
    step();
    cnt = 1;
    while (!cur_ov && cnt < 100) begin step(); cnt++; end
    check("tp_period", cnt, 10);
    check("tp_res2", cur_res, er);
    drive_in(1'b0, 0, 0, 0);
    step();
    drive_ordy(1'b0);
    check("tp_idle", cur_ir, 1);

    // Reset priority over in_valid on the same edge.
    reset = 1'b1;
    drive_in(1'b1, 5, 7, 11);
    step();
    drive_in(1'b0, 0, 0, 0);
    reset = 1'b0;
    step();
    check("rp_not_accepted", {cur_busy, cur_ov, cur_ir}, 3'b001);

    // Abort in CALC, then restart cleanly.
    drive_in(1'b1, 200, 100, 251);
    step();
    drive_in(1'b0, 0, 0, 0);
    repeat (3) step();
    check("ab_busy", cur_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ab_ready", cur_ir, 1);
    check("ab_busy0", cur_busy, 0);
    check("ab_res0", cur_res, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cur_ov !== 1'b0) bad++;
    end
    check("ab_no_stale", bad, 0);
    run_op(1'b0, 3, 4, 5, "restart");
    check("restart_val", cur_res, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
